ps2_scancode_decoder: RTL and testbench

//  Downstream stage of the PS/2 keyboard receiver. Takes each raw received byte and its

---
 rtl/ps2_scancode_decoder.sv | 176 +++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: resyncs the receiver byte strobe, folds E0/F0/E1 prefixes into key events, queues them.
// Latency: push two clk edges after s1 first samples byte_valid high; event visible on event_* the cycle after the push.
// Backpressure: show-ahead FIFO of DEPTH events on valid/ready; a push into a full FIFO with no pop drops it and sets overflow.
//
// Ports:
//   clk, rst                  system clock, async active-high reset
//   byte_in, byte_valid       raw byte + valid from the PS/2 receiver domain
//   event_code/ext/rel/valid  head-of-FIFO key event; event_ready pops it
//   overflow, ovf_clr         sticky drop flag and its synchronous clear
//   fifo_count                number of stored events (0..DEPTH)
module ps2_scancode_decoder #(
    parameter int DEPTH     = 8,
    parameter int PAUSE_LEN = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic [7:0]               event_code,
    output logic                     event_ext,
    output logic                     event_rel,
    output logic                     event_valid,
    input  logic                     event_ready,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(PAUSE_LEN + 1);

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } evt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_REL,
        ST_EXTREL,
        ST_PAUSE
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   skip_q, skip_d;
    logic            s1_q, s2_q, s3_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    evt_t            mem [DEPTH];

    logic            strobe;
    logic            push;
    evt_t            push_dat;
    logic            full, empty, pop, push_ok, ovf_set;

    // Sync flops reset high so a byte_valid already high at reset release
    // does not look like a fresh rising edge.
    assign strobe = s2_q & ~s3_q;

    // Prefix decoding; only advances on the one-cycle strobe.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        push     = 1'b0;
        push_dat = '0;
        if (strobe) begin
            case (state_q)
                ST_IDLE: begin
                    case (byte_in)
                        8'hE0: state_d = ST_EXT;
                        8'hF0: state_d = ST_REL;
                        8'hE1: begin
                            state_d = ST_PAUSE;
                            skip_d  = SW'(PAUSE_LEN);
                        end
                        // Self-test / ack / resend / error replies: not key events.
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = ST_IDLE;
                        default: begin
                            push     = 1'b1;
                            push_dat = '{ext: 1'b0, rel: 1'b0, code: byte_in};
                        end
                    endcase
                end
                ST_EXT: begin
                    if (byte_in == 8'hF0) begin
                        state_d = ST_EXTREL;
                    end else if (byte_in != 8'hE0) begin
                        push     = 1'b1;
                        push_dat = '{ext: 1'b1, rel: 1'b0, code: byte_in};
                        state_d  = ST_IDLE;
                    end
                end
                ST_REL: begin
                    push     = 1'b1;
                    push_dat = '{ext: 1'b0, rel: 1'b1, code: byte_in};
                    state_d  = ST_IDLE;
                end
                ST_EXTREL: begin
                    push     = 1'b1;
                    push_dat = '{ext: 1'b1, rel: 1'b1, code: byte_in};
                    state_d  = ST_IDLE;
                end
                ST_PAUSE: begin
                    // The whole Pause sequence collapses to one extended 77 event.
                    if (skip_q == SW'(1)) begin
                        push     = 1'b1;
                        push_dat = '{ext: 1'b1, rel: 1'b0, code: 8'h77};
                        skip_d   = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        skip_d = skip_q - SW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head pops the same cycle.
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        pop        = ~empty & event_ready;
        push_ok    = push & (~full | pop);
        ovf_set    = push & full & ~pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = (overflow_q & ~ovf_clr) | ovf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            s3_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            s1_q       <= byte_valid;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: contents are only visible while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end

    assign event_valid = ~empty;
    assign event_code  = empty ? 8'h00 : mem[rd_ptr_q].code;
    assign event_ext   = ~empty & mem[rd_ptr_q].ext;
    assign event_rel   = ~empty & mem[rd_ptr_q].rel;
    assign overflow    = overflow_q;
    assign fifo_count  = count_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: prefix decoding, pause absorption, FIFO fill/overflow, reset, latency.
// Latency: n/a (bench). Inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: event_ready held low except during explicit pops.
module tb_ps2_scancode_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_rel;
    logic       event_valid;
    logic       event_ready;
    logic       overflow;
    logic       ovf_clr;
    logic [3:0] fifo_count;

    int vectors     = 0;
    int miscompares = 0;

    ps2_scancode_decoder #(.DEPTH(8), .PAUSE_LEN(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .event_code  (event_code),
        .event_ext   (event_ext),
        .event_rel   (event_rel),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One received byte: valid high for 4 clk then low for 4 clk.
    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        repeat (4) step();
        byte_valid = 1'b0;
        repeat (4) step();
    endtask

    // Check the head event {ext,rel,code} then pop it.
    task automatic pop_chk(input string tag, input logic ext, input logic rel, input logic [7:0] code);
        chk({tag, "_valid"}, 32'(event_valid), 32'd1);
        chk({tag, "_evt"}, {22'd0, event_ext, event_rel, event_code}, {22'd0, ext, rel, code});
        event_ready = 1'b1;
        step();
        event_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        event_ready = 1'b0;
        ovf_clr     = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(event_valid), 32'd0);
        chk("rst_code",  32'(event_code), 32'd0);
        chk("rst_ext_rel", {30'd0, event_ext, event_rel}, 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);

        // 1: make then break
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("t1_count", 32'(fifo_count), 32'd2);
        pop_chk("t1_make", 1'b0, 1'b0, 8'h1C);
        pop_chk("t1_break", 1'b0, 1'b1, 8'h1C);
        chk("t1_empty", 32'(fifo_count), 32'd0);

        // 2: extended make and break
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("t2_count", 32'(fifo_count), 32'd2);
        pop_chk("t2_make", 1'b1, 1'b0, 8'h75);
        pop_chk("t2_break", 1'b1, 1'b1, 8'h75);

        // 3: pause sequence gives exactly one event, then back to IDLE
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        chk("t3_count", 32'(fifo_count), 32'd1);
        pop_chk("t3_pause", 1'b1, 1'b0, 8'h77);
        send_byte(8'h1C);
        pop_chk("t3_idle", 1'b0, 1'b0, 8'h1C);

        // 4: fill, overflow, clear, pop+push while full
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
        chk("t4_full_count", 32'(fifo_count), 32'd8);
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        chk("t4_head", 32'(event_code), 32'h10);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        // Byte 20: s1 samples at edge E, push at E+2; pop on that same edge.
        byte_in    = 8'h20;
        byte_valid = 1'b1;
        step();               // E
        step();               // E+1
        event_ready = 1'b1;
        step();               // E+2: push and pop together
        event_ready = 1'b0;
        chk("t4_pp_count", 32'(fifo_count), 32'd8);
        chk("t4_pp_ovf", 32'(overflow), 32'd0);
        byte_valid = 1'b0;
        repeat (4) step();
        chk("t4_pp_count2", 32'(fifo_count), 32'd8);
        for (int i = 1; i < 8; i++) pop_chk("t4_drain", 1'b0, 1'b0, 8'h10 + 8'(i));
        pop_chk("t4_drain_last", 1'b0, 1'b0, 8'h20);
        chk("t4_drained", 32'(fifo_count), 32'd0);

        // 5: reset discards the E0 prefix
        send_byte(8'hE0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        send_byte(8'h75);
        chk("t5_count", 32'(fifo_count), 32'd1);
        pop_chk("t5_evt", 1'b0, 1'b0, 8'h75);

        // 6: reply bytes produce nothing
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'hFE);
        chk("t6_count", 32'(fifo_count), 32'd0);
        chk("t6_valid", 32'(event_valid), 32'd0);

        // 6: latency
        byte_in    = 8'h2A;
        byte_valid = 1'b1;
        step();               // E: s1 samples high
        chk("lat_e0", 32'(event_valid), 32'd0);
        step();               // E+1
        chk("lat_e1", 32'(event_valid), 32'd0);
        step();               // E+2: push
        chk("lat_e2", 32'(event_valid), 32'd1);
        byte_valid = 1'b0;
        repeat (4) step();
        chk("lat_count", 32'(fifo_count), 32'd1);
        pop_chk("lat_evt", 1'b0, 1'b0, 8'h2A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end
endmodule
